// File: rtl/m_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit lookahead slice per stage,
// valid-tagged tokens, global stall via en, registered sum/carry/overflow outputs.
module m_cla_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             out_valid
);
  localparam int NSEG = WIDTH / SEG;

  // Result layout: {carry out, carry into slice MSB, SEG-bit sum}.
  function automatic logic [SEG+1:0] cla_slice(input logic [SEG-1:0] x,
                                               input logic [SEG-1:0] y,
                                               input logic           cin);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    for (int j = 0; j < SEG; j++) c[j+1] = g[j] | (p[j] & c[j]);
    return {c[SEG], c[SEG-1], p ^ c[SEG-1:0]};
  endfunction

  logic [WIDTH-1:0] opa_p [0:NSEG-1];
  logic [WIDTH-1:0] opb_p [0:NSEG-1];
  logic [WIDTH-1:0] sum_p [0:NSEG-1];
  logic             cry_p [0:NSEG-1];
  logic             vld_p [0:NSEG-1];

  logic [SEG+1:0]   res      [0:NSEG-1];
  logic [WIDTH-1:0] sum_next [0:NSEG-1];

  // Stage k evaluates slice k on the operands and carry it holds.
  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      res[k]      = cla_slice(opa_p[k][k*SEG +: SEG], opb_p[k][k*SEG +: SEG], cry_p[k]);
      sum_next[k] = sum_p[k];
      sum_next[k][k*SEG +: SEG] = res[k][SEG-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSEG; i++) begin
        opa_p[i] <= '0;
        opb_p[i] <= '0;
        sum_p[i] <= '0;
        cry_p[i] <= 1'b0;
        vld_p[i] <= 1'b0;
      end
      s         <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      // Stage 0: operand capture, subtract folded into b and carry-in.
      opa_p[0] <= a;
      opb_p[0] <= sub ? ~b : b;
      sum_p[0] <= '0;
      cry_p[0] <= sub | ci;
      vld_p[0] <= in_valid;
      // Stages 1..NSEG-1: finished low bits and untouched high operands move on.
      for (int i = 1; i < NSEG; i++) begin
        opa_p[i] <= opa_p[i-1];
        opb_p[i] <= opb_p[i-1];
        sum_p[i] <= sum_next[i-1];
        cry_p[i] <= res[i-1][SEG+1];
        vld_p[i] <= vld_p[i-1];
      end
      // Final stage: outputs change only for a real token, bubbles leave them alone.
      out_valid <= vld_p[NSEG-1];
      if (vld_p[NSEG-1]) begin
        s   <= sum_next[NSEG-1];
        co  <= res[NSEG-1][SEG+1];
        ovf <= res[NSEG-1][SEG+1] ^ res[NSEG-1][SEG];
      end
    end
  end
endmodule

// File: tb/tb_m_cla_pipe.sv
// Bench for m_cla_pipe: vector table through a scoreboard on the 32-bit instance,
// stall/reset sequences, and small 16-bit and 8-bit instances.
module tb_m_cla_pipe;
  logic clock = 1'b0;
  logic reset, en;
  logic        in_valid, ci, sub;
  logic [31:0] a, b, s;
  logic        co, ovf, out_valid;
  logic        iv16, iv8, co16, ovf16, ov16, co8, ovf8, ov8;
  logic [15:0] a16, b16, s16;
  logic [7:0]  a8, b8, s8;

  always #5 clock = ~clock;

  m_cla_pipe #(.WIDTH(32), .SEG(8)) dut (
    .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .a(a), .b(b),
    .ci(ci), .sub(sub), .s(s), .co(co), .ovf(ovf), .out_valid(out_valid));
  m_cla_pipe #(.WIDTH(16), .SEG(4)) dut16 (
    .clock(clock), .reset(reset), .en(en), .in_valid(iv16), .a(a16), .b(b16),
    .ci(1'b0), .sub(1'b0), .s(s16), .co(co16), .ovf(ovf16), .out_valid(ov16));
  m_cla_pipe #(.WIDTH(8), .SEG(8)) dut8 (
    .clock(clock), .reset(reset), .en(en), .in_valid(iv8), .a(a8), .b(b8),
    .ci(1'b0), .sub(1'b0), .s(s8), .co(co8), .ovf(ovf8), .out_valid(ov8));

  typedef struct {
    logic [31:0] a, b;
    logic        ci, sub;
    logic [31:0] es;
    logic        eco, eovf;
  } vec_t;
  typedef struct {
    logic [31:0] s;
    logic        co, ovf;
    int          cap;
  } sb_t;

  vec_t vec [16];
  sb_t  sbq [$];
  int   nchk = 0, npass = 0, en_cnt = 0, nvalid = 0;
  logic [31:0] cur_s;
  logic        cur_co, cur_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic sb);
    logic [31:0] be;
    logic [32:0] r;
    logic        ov;
    be = sb ? ~y : y;
    r  = {1'b0, x} + {1'b0, be} + {32'd0, (sb ? 1'b1 : c)};
    ov = (x[31] == be[31]) && (r[31] != x[31]);
    return {ov, r};
  endfunction

  // Scoreboard: push on capture, pop when a fresh result appears on an enabled edge.
  always @(posedge clock) begin
    logic ev, iv, rs;
    sb_t  e;
    ev = en; iv = in_valid; rs = reset;
    e.s = cur_s; e.co = cur_co; e.ovf = cur_ovf;
    #1;
    if (!rs && ev) begin
      en_cnt++;
      if (iv) begin
        e.cap = en_cnt;
        sbq.push_back(e);
      end
      if (out_valid) begin
        nvalid++;
        if (sbq.size() == 0) begin
          nchk++;
          $display("FAIL unexpected_valid: got out_valid=1, expected 0 (s=%h)", s);
        end else begin
          e = sbq.pop_front();
          chk("sum", {32'd0, s}, {32'd0, e.s});
          chk("carry", {63'd0, co}, {63'd0, e.co});
          chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
          chk("latency", 64'(en_cnt - e.cap), 64'd4);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic c,
                       input logic sb, input logic [31:0] es, input logic eco, input logic eovf);
    @(negedge clock);
    a = x; b = y; ci = c; sub = sb; in_valid = 1'b1;
    cur_s = es; cur_co = eco; cur_ovf = eovf;
  endtask

  task automatic bubble();
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 40 && sbq.size() > 0; i++) @(negedge clock);
    if (sbq.size() > 0) begin
      nchk++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    logic [33:0] m;
    int          nv;
    vec[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vec[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vec[2] = '{32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vec[3] = '{32'h135F_A562, 32'h3561_4642, 1'b0, 1'b0, 32'h48C0_EBA4, 1'b0, 1'b0};
    vec[4] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vec[5] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vec[6] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vec[7] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    for (int i = 8; i < 16; i++) begin
      vec[i].a = $urandom; vec[i].b = $urandom;
      vec[i].ci = 1'($urandom_range(1)); vec[i].sub = 1'($urandom_range(1));
      m = model(vec[i].a, vec[i].b, vec[i].ci, vec[i].sub);
      vec[i].es = m[31:0]; vec[i].eco = m[32]; vec[i].eovf = m[33];
    end

    reset = 1'b1; en = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    iv16 = 1'b0; iv8 = 1'b0; a16 = '0; b16 = '0; a8 = '0; b8 = '0;
    cur_s = '0; cur_co = 1'b0; cur_ovf = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_s", {32'd0, s}, 64'd0);
    chk("reset_co", {63'd0, co}, 64'd0);
    chk("reset_ovf", {63'd0, ovf}, 64'd0);
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b0;

    // Back-to-back table tokens.
    for (int i = 0; i < 16; i++)
      drive(vec[i].a, vec[i].b, vec[i].ci, vec[i].sub, vec[i].es, vec[i].eco, vec[i].eovf);
    bubble();
    drain();
    repeat (2) @(negedge clock);
    chk("hold_after_bubbles", {32'd0, s}, {32'd0, vec[15].es});

    // Stall mid-pipe after two enabled edges.
    drive(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    bubble();
    @(negedge clock);
    en = 1'b0;
    repeat (3) @(negedge clock);
    en = 1'b1;
    drain();

    // Stall while a result sits on the outputs.
    drive(32'h0000_1234, 32'h1, 1'b0, 1'b0, 32'h0000_1235, 1'b0, 1'b0);
    bubble();
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clock);
    nv = nvalid;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_s", {32'd0, s}, 64'h1235);
    end
    en = 1'b1;
    @(negedge clock);
    chk("valid_after_stall", {63'd0, out_valid}, 64'd0);
    chk("no_duplicate", 64'(nvalid - nv), 64'd0);
    drain();

    // Asynchronous reset with two tokens in flight.
    drive(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0);
    drive(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0, 32'h1010_1010, 1'b0, 1'b0);
    bubble();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_s", {32'd0, s}, 64'd0);
    chk("async_reset_valid", {63'd0, out_valid}, 64'd0);
    sbq.delete();
    @(negedge clock);
    reset = 1'b0;
    nv = nvalid;
    repeat (8) @(negedge clock);
    chk("no_valid_after_reset", 64'(nvalid - nv), 64'd0);
    drive(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    bubble();
    drain();

    // Narrow instances.
    @(negedge clock);
    a16 = 16'hFFFF; b16 = 16'h0001; iv16 = 1'b1;
    a8 = 8'h80; b8 = 8'h80; iv8 = 1'b1;
    @(negedge clock);
    iv16 = 1'b0; iv8 = 1'b0;
    chk("w8_valid_early", {63'd0, ov8}, 64'd0);
    @(negedge clock);
    chk("w8_valid", {63'd0, ov8}, 64'd1);
    chk("w8_s", {56'd0, s8}, 64'h00);
    chk("w8_co", {63'd0, co8}, 64'd1);
    chk("w8_ovf", {63'd0, ovf8}, 64'd1);
    repeat (2) @(negedge clock);
    chk("w16_valid_early", {63'd0, ov16}, 64'd0);
    @(negedge clock);
    chk("w16_valid", {63'd0, ov16}, 64'd1);
    chk("w16_s", {48'd0, s16}, 64'h0000);
    chk("w16_co", {63'd0, co16}, 64'd1);
    @(negedge clock);
    chk("w16_pulse", {63'd0, ov16}, 64'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
